// File: rtl/sys_bus_mst.sv
// sys_bus_mst: single-outstanding command-to-system-bus master.
// Accepts one read/write command, issues a one-cycle strobe, waits for
// ack/err (or a timeout when SYS_BUS_MST_TIMEOUT_EN is defined) and
// returns one response held until rsp_rdy.
// Ports: clk, rstn (async active-low);
//   cmd_*  command handshake (vld/rdy, wen, addr, wdata);
//   rsp_*  response handshake (vld/rdy, rdata, err, tmo);
//   bus_*  system bus (addr, wdata, wen, ren strobes, rdata, ack, err).
// Parameters: AW, DW (bus widths), TW (timeout counter width),
//   TMO (timeout in WAIT cycles, 1..2**TW-1).
module sys_bus_mst #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TW  = 8,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_vld,
    output logic          cmd_rdy,
    input  logic          cmd_wen,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_vld,
    input  logic          rsp_rdy,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_tmo,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_wen,
    output logic          bus_ren,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack,
    input  logic          bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

    state_t state_q, state_d;
    logic   rdy_q;
    logic   wen_q;
    logic   accept;
    logic   finish;

    generate
        if (TMO < 1 || TMO > (2**TW) - 1) begin : g_bad_tmo
            $error("sys_bus_mst: TMO must be in 1..2**TW-1");
        end
    endgenerate

`ifdef SYS_BUS_MST_TIMEOUT_EN
    localparam logic [TW-1:0] TLIM = TW'(TMO - 1);

    logic [TW-1:0] cnt_q;
    logic          tmo_q;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_vld && rdy_q) begin
                    accept  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: state_d = WAIT;
            WAIT: begin
                if (bus_ack || bus_err) begin
                    state_d = RSP;
                end
`ifdef SYS_BUS_MST_TIMEOUT_EN
                else if (cnt_q == TLIM) begin
                    state_d = RSP;
                end
`endif
            end
            RSP: begin
                if (rsp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign finish = (state_q == WAIT) && (state_d == RSP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_addr  <= '0;
            bus_wdata <= '0;
            wen_q     <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                bus_addr  <= cmd_addr;
                bus_wdata <= cmd_wdata;
                wen_q     <= cmd_wen;
            end
            if (finish) begin
                if (bus_err) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end else if (bus_ack) begin
                    rsp_rdata <= wen_q ? '0 : bus_rdata;
                    rsp_err   <= 1'b0;
                end else begin
                    // only reachable through the timeout
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end
        end
    end

`ifdef SYS_BUS_MST_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (state_q == REQ) begin
                cnt_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + TW'(1);
            end
            if (finish) begin
                tmo_q <= !(bus_ack || bus_err);
            end
        end
    end

    assign rsp_tmo = tmo_q;
`else
    assign rsp_tmo = 1'b0;
`endif

    assign cmd_rdy = rdy_q && (state_q == IDLE);
    assign rsp_vld = (state_q == RSP);
    assign bus_wen = (state_q == REQ) && wen_q;
    assign bus_ren = (state_q == REQ) && !wen_q;

endmodule

// File: tb/tb_sys_bus_mst.sv
// tb_sys_bus_mst: self-checking bench for sys_bus_mst.
// Directed vector table, hand sequences and randomized transactions.
module tb_sys_bus_mst;

    localparam int TMO_TB = 4;
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;
    localparam logic [31:0] RMASK = 32'h5A5A_C3C3;

    logic        clk;
    logic        rstn;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic        cmd_wen;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_tmo;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_wen;
    logic        bus_ren;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    int n_chk;
    int n_pass;

    sys_bus_mst #(
        .AW (32),
        .DW (32),
        .TW (8),
        .TMO(TMO_TB)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .cmd_wen  (cmd_wen),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .rsp_tmo  (rsp_tmo),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_wen  (bus_wen),
        .bus_ren  (bus_ren),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          k;
        int          kind;
        logic [31:0] rd;
        int          stall;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_tmo;
        int          e_lat;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Reference: the response comes from the first WAIT cycle carrying
    // ack or err (err wins); if none arrives by WAIT cycle TMO the
    // timeout fires. Latency counts the REQ cycle and the RSP cycle.
    function automatic void model(input logic w, input int k,
                                  input int kind, input logic [31:0] rd,
                                  output logic [31:0] er,
                                  output logic ee, output logic et,
                                  output int el);
        int ev;
        bit to;
        ev = (kind == K_NONE) ? 1000 : k;
        to = 1'b0;
`ifdef SYS_BUS_MST_TIMEOUT_EN
        if (ev > TMO_TB) begin
            ev = TMO_TB;
            to = 1'b1;
        end
`endif
        el = ev + 2;
        er = '0;
        ee = 1'b0;
        et = 1'b0;
        if (to) begin
            ee = 1'b1;
            et = 1'b1;
        end else if (kind == K_ACK) begin
            er = w ? 32'h0 : rd;
        end else begin
            ee = 1'b1;
        end
    endfunction

    // Runs one transaction from an IDLE negedge. The event (kind) is
    // placed in WAIT cycle k; REQ and RSP cycles get random ack/err noise.
    task automatic run_txn(input logic w, input logic [31:0] a,
                           input logic [31:0] d, input int k,
                           input int kind, input logic [31:0] rd,
                           input int stall,
                           output logic [31:0] g_rdata,
                           output logic g_err, output logic g_tmo,
                           output int g_lat);
        bit hold_ok;
        bit rsp_ok;
        bit rdy_ok;
        bit done;
        int nw;
        int nr;
        hold_ok = 1'b1;
        rsp_ok  = 1'b1;
        rdy_ok  = 1'b1;
        done    = 1'b0;
        nw      = 0;
        nr      = 0;
        g_lat   = -1;
        g_rdata = '0;
        g_err   = 1'b0;
        g_tmo   = 1'b0;
        check("rdy_idle", 64'(cmd_rdy), 64'd1);
        cmd_vld   = 1'b1;
        cmd_wen   = w;
        cmd_addr  = a;
        cmd_wdata = d;
        rsp_rdy   = 1'b0;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        @(negedge clk);
        cmd_vld   = 1'b0;
        cmd_wen   = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        for (int c = 1; c < 300 && !done; c++) begin
            if (bus_wen) nw++;
            if (bus_ren) nr++;
            if (bus_addr !== a || bus_wdata !== d) hold_ok = 1'b0;
            if (cmd_rdy) rdy_ok = 1'b0;
            if (rsp_vld) begin
                g_lat   = c;
                g_rdata = rsp_rdata;
                g_err   = rsp_err;
                g_tmo   = rsp_tmo;
                for (int s = 0; s <= stall; s++) begin
                    bus_ack   = 1'($urandom);
                    bus_err   = 1'($urandom);
                    bus_rdata = $urandom;
                    rsp_rdy   = (s == stall);
                    @(negedge clk);
                    if (s < stall) begin
                        if (!rsp_vld || rsp_rdata !== g_rdata ||
                            rsp_err !== g_err || rsp_tmo !== g_tmo)
                            rsp_ok = 1'b0;
                        if (cmd_rdy || bus_wen || bus_ren) rdy_ok = 1'b0;
                        if (bus_addr !== a || bus_wdata !== d)
                            hold_ok = 1'b0;
                    end
                end
                done = 1'b1;
            end else begin
                bus_ack   = 1'b0;
                bus_err   = 1'b0;
                bus_rdata = $urandom;
                if (c == 1) begin
                    bus_ack = 1'($urandom);
                    bus_err = 1'($urandom);
                end else if (kind != K_NONE && (c - 1) == k) begin
                    bus_rdata = rd;
                    bus_ack   = (kind == K_ACK || kind == K_BOTH);
                    bus_err   = (kind == K_ERR || kind == K_BOTH);
                end
                @(negedge clk);
            end
        end
        rsp_rdy = 1'b0;
        bus_ack = 1'b0;
        bus_err = 1'b0;
        if (!done) begin
            check("txn_no_response", 64'd0, 64'd1);
        end else begin
            check("rsp_drop", 64'(rsp_vld), 64'd0);
            check("rdy_back", 64'(cmd_rdy), 64'd1);
        end
        check("strobes", {32'(nw), 32'(nr)},
              {32'(w ? 1 : 0), 32'(w ? 0 : 1)});
        check("bus_hold", 64'(hold_ok), 64'd1);
        check("rsp_hold", 64'(rsp_ok), 64'd1);
        check("rdy_busy", 64'(rdy_ok), 64'd1);
    endtask

    initial begin
        vec_t        tbl[8];
        logic [31:0] g_rd;
        logic        g_er;
        logic        g_to;
        int          g_lt;
        logic [31:0] q[$];
        logic [31:0] e;
        int          ci;
        bit          acc;
        bit          b_ok;
        bit          ord_ok;
        int          nrsp;
        int          nstb;
        bit          quiet;

        n_chk = 0;
        n_pass = 0;

        tbl[0] = '{1'b1, 32'h4000_0004, 32'h3, 1, K_ACK, 32'hDEAD_BEEF,
                   0, 32'h0, 1'b0, 1'b0, 3};
`ifdef SYS_BUS_MST_TIMEOUT_EN
        tbl[1] = '{1'b0, 32'h4000_0000, 32'h0, 5, K_ACK, 32'hA5,
                   4, 32'h0, 1'b1, 1'b1, 6};
`else
        tbl[1] = '{1'b0, 32'h4000_0000, 32'h0, 5, K_ACK, 32'hA5,
                   4, 32'hA5, 1'b0, 1'b0, 7};
`endif
        tbl[2] = '{1'b0, 32'h4000_0008, 32'h0, 1, K_BOTH, 32'h1234,
                   1, 32'h0, 1'b1, 1'b0, 3};
        tbl[3] = '{1'b1, 32'h4000_000C, 32'h77, 2, K_ERR, 32'h5555,
                   0, 32'h0, 1'b1, 1'b0, 4};
        tbl[4] = '{1'b0, 32'h4000_0010, 32'h0, 3, K_ACK, 32'hFFFF_FFFF,
                   2, 32'hFFFF_FFFF, 1'b0, 1'b0, 5};
`ifdef SYS_BUS_MST_TIMEOUT_EN
        tbl[5] = '{1'b0, 32'h4000_0014, 32'h0, 20, K_ACK, 32'h77,
                   0, 32'h0, 1'b1, 1'b1, 6};
`else
        tbl[5] = '{1'b0, 32'h4000_0014, 32'h0, 20, K_ACK, 32'h77,
                   0, 32'h77, 1'b0, 1'b0, 22};
`endif
        tbl[6] = '{1'b0, 32'h4000_0018, 32'h0, 4, K_ACK, 32'h99,
                   1, 32'h99, 1'b0, 1'b0, 6};
        tbl[7] = '{1'b1, 32'h4000_001C, 32'hAB, 4, K_ERR, 32'h1,
                   0, 32'h0, 1'b1, 1'b0, 6};

        rstn      = 1'b0;
        cmd_vld   = 1'b0;
        cmd_wen   = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_rdy   = 1'b0;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
        check("rst_ctl", {60'd0, rsp_vld, bus_wen, bus_ren, rsp_err},
              64'd0);
        check("rst_bus", {bus_addr, bus_wdata}, 64'd0);
        check("rst_rsp", {31'd0, rsp_tmo, rsp_rdata}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", 64'(cmd_rdy), 64'd1);

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].k, tbl[i].kind,
                    tbl[i].rd, tbl[i].stall, g_rd, g_er, g_to, g_lt);
            check($sformatf("vec%0d_rdata", i), 64'(g_rd),
                  64'(tbl[i].e_rdata));
            check($sformatf("vec%0d_err", i), 64'(g_er), 64'(tbl[i].e_err));
            check($sformatf("vec%0d_tmo", i), 64'(g_to), 64'(tbl[i].e_tmo));
            check($sformatf("vec%0d_lat", i), 64'(g_lt), 64'(tbl[i].e_lat));
        end

        // back-to-back: cmd_vld held, ack held high, rsp_rdy held high
        ci        = 0;
        acc       = 1'b0;
        b_ok      = 1'b1;
        ord_ok    = 1'b1;
        nrsp      = 0;
        nstb      = 0;
        cmd_vld   = 1'b1;
        cmd_wen   = 1'b0;
        cmd_addr  = 32'h1000_0000;
        cmd_wdata = 32'h0;
        bus_ack   = 1'b1;
        bus_err   = 1'b0;
        rsp_rdy   = 1'b1;
        for (int cy = 0; cy < 40; cy++) begin
            if (acc) begin
                acc = 1'b0;
                if (ci < 6) begin
                    cmd_wen   = ci[0];
                    cmd_addr  = 32'h1000_0000 + 32'(ci * 4);
                    cmd_wdata = 32'(ci);
                end else begin
                    cmd_vld = 1'b0;
                end
            end
            if (bus_wen && bus_ren) b_ok = 1'b0;
            if (bus_wen || bus_ren) nstb++;
            if (cmd_rdy && q.size() > 0) b_ok = 1'b0;
            if (rsp_vld) begin
                nrsp++;
                if (q.size() == 0) begin
                    ord_ok = 1'b0;
                end else begin
                    e = q.pop_front();
                    if (rsp_rdata !== e || rsp_err !== 1'b0) ord_ok = 1'b0;
                end
            end
            if (cmd_rdy && cmd_vld) begin
                q.push_back(cmd_wen ? 32'h0 : (cmd_addr ^ RMASK));
                ci++;
                acc = 1'b1;
            end
            bus_rdata = bus_addr ^ RMASK;
            @(negedge clk);
        end
        bus_ack = 1'b0;
        rsp_rdy = 1'b0;
        cmd_vld = 1'b0;
        check("b2b_rsp_count", 64'(nrsp), 64'd6);
        check("b2b_strobes", 64'(nstb), 64'd6);
        check("b2b_protocol", 64'(b_ok), 64'd1);
        check("b2b_order", 64'(ord_ok), 64'd1);

        // reset pulsed while waiting on the bus
        cmd_vld   = 1'b1;
        cmd_wen   = 1'b0;
        cmd_addr  = 32'h2000_0000;
        cmd_wdata = 32'h0;
        @(negedge clk);
        cmd_vld = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("rstw_ctl", {60'd0, bus_wen, bus_ren, rsp_vld, cmd_rdy},
              64'd0);
        check("rstw_addr", 64'(bus_addr), 64'd0);
        @(negedge clk);
        rstn    = 1'b1;
        bus_ack = 1'b1;
        @(negedge clk);
        check("rstw_rdy", 64'(cmd_rdy), 64'd1);
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (rsp_vld || bus_wen || bus_ren) quiet = 1'b0;
            @(negedge clk);
        end
        bus_ack = 1'b0;
        check("rstw_no_rsp", 64'(quiet), 64'd1);

        for (int i = 0; i < 40; i++) begin
            logic        w;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] rd;
            int          k;
            int          kind;
            int          st;
            logic [31:0] er;
            logic        ee;
            logic        et;
            int          el;
            w  = 1'($urandom);
            a  = $urandom;
            d  = $urandom;
            rd = $urandom;
            k  = int'($urandom_range(1, 6));
`ifdef SYS_BUS_MST_TIMEOUT_EN
            kind = int'($urandom_range(0, 3));
`else
            kind = int'($urandom_range(0, 2));
`endif
            st = int'($urandom_range(0, 3));
            model(w, k, kind, rd, er, ee, et, el);
            run_txn(w, a, d, k, kind, rd, st, g_rd, g_er, g_to, g_lt);
            check($sformatf("rnd%0d_rdata", i), 64'(g_rd), 64'(er));
            check($sformatf("rnd%0d_err", i), 64'(g_er), 64'(ee));
            check($sformatf("rnd%0d_tmo", i), 64'(g_to), 64'(et));
            check($sformatf("rnd%0d_lat", i), 64'(g_lt), 64'(el));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
